// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// levels, occupancy count, sticky overflow/underflow and optional FWFT read.
module fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              wr_acc;
  logic              rd_acc;

  // Flags decode the registered count only, so they lag an edge by one cycle.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop frees a slot in the same edge, so a full FIFO still takes wr&rd.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr && !wr_acc)  overflow_q <= 1'b1;
      else if (err_clr)   overflow_q <= 1'b0;
      if (rd && !rd_acc)  underflow_q <= 1'b1;
      else if (err_clr)   underflow_q <= 1'b0;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: scoreboard-driven checks of a standard
// instance plus a first-word-fall-through instance.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n, wr, rd, err_clr;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       rst_n_b, wr_b, rd_b, clr_b;
  logic [7:0] din_b, dout_b;
  logic       full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [4:0] count_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  int         mcount;
  logic [7:0] mdout;
  bit         mov, mun;

  always #5 clk = ~clk;

  fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd), .err_clr(err_clr),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n_b), .wr(wr_b), .data_in(din_b), .rd(rd_b), .err_clr(clr_b),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ov_b), .underflow(un_b)
  );

  // One clock of stimulus on the standard instance; the model decides acceptance.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c,
                      output bit popped, output logic [7:0] exp_d);
    bit r_acc, w_acc;
    wr = w; data_in = d; rd = r; err_clr = c;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    popped = 1'b0; exp_d = 8'h00;
    r_acc = r && (mcount != 0);
    w_acc = w && ((mcount != 16) || r_acc);
    if (r_acc) begin exp_d = sb.pop_front(); popped = 1'b1; mdout = exp_d; end
    if (w_acc) sb.push_back(d);
    mcount = mcount + int'(w_acc) - int'(r_acc);
    if (w && !w_acc) mov = 1'b1; else if (c) mov = 1'b0;
    if (r && !r_acc) mun = 1'b1; else if (c) mun = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr = 1'b1; data_in = 8'h77; rd = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b/%b want=1/1", empty, almost_empty); end
    total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b/%b want=0/0", full, almost_full); end
    total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout got=%h want=00", data_out); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_sticky got=%b/%b want=0/0", overflow, underflow); end
    rst_n = 1'b1; wr = 1'b0;
    sb.delete(); mcount = 0; mdout = 8'h00; mov = 1'b0; mun = 1'b0;
    @(posedge clk); #1;
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_no_write got=%0d want=0", count); end
  endtask

  task automatic test_fill_overflow;
    bit p; logic [7:0] e;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, p, e);
      total++; if (count !== 5'(mcount)) begin bad++; $display("[TB] FAIL fill_count got=%0d want=%0d", count, mcount); end
      total++; if (almost_empty !== (mcount <= 4)) begin bad++; $display("[TB] FAIL fill_ae n=%0d got=%b want=%b", i, almost_empty, mcount <= 4); end
      total++; if (almost_full !== (mcount >= 12)) begin bad++; $display("[TB] FAIL fill_af n=%0d got=%b want=%b", i, almost_full, mcount >= 12); end
      total++; if (full !== (mcount == 16)) begin bad++; $display("[TB] FAIL fill_full n=%0d got=%b want=%b", i, full, mcount == 16); end
    end
    step(1'b1, 8'h11, 1'b0, 1'b0, p, e);
    total++; if (overflow !== mov) begin bad++; $display("[TB] FAIL overflow_set got=%b want=%b", overflow, mov); end
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL overflow_count got=%0d want=16", count); end
  endtask

  task automatic test_drain_underflow;
    bit p; logic [7:0] e;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, e);
      total++; if (!p || data_out !== e) begin bad++; $display("[TB] FAIL drain_data got=%h want=%h", data_out, e); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty got=%b want=1", empty); end
    step(1'b0, 8'h00, 1'b1, 1'b0, p, e);
    total++; if (underflow !== mun) begin bad++; $display("[TB] FAIL underflow_set got=%b want=%b", underflow, mun); end
    total++; if (data_out !== mdout) begin bad++; $display("[TB] FAIL underflow_hold got=%h want=%h", data_out, mdout); end
    step(1'b0, 8'h00, 1'b0, 1'b1, p, e);
    total++; if (overflow !== mov || underflow !== mun) begin bad++; $display("[TB] FAIL err_clr got=%b/%b want=%b/%b", overflow, underflow, mov, mun); end
  endtask

  task automatic test_boundary;
    bit p; logic [7:0] e;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, p, e);
    step(1'b1, 8'hAA, 1'b1, 1'b0, p, e);
    total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL full_wrrd_count got=%0d want=16", count); end
    total++; if (data_out !== e) begin bad++; $display("[TB] FAIL full_wrrd_data got=%h want=%h", data_out, e); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, e);
      total++; if (data_out !== e) begin bad++; $display("[TB] FAIL full_order got=%h want=%h", data_out, e); end
    end
    total++; if (data_out !== 8'hAA) begin bad++; $display("[TB] FAIL aa_last got=%h want=aa", data_out); end
    step(1'b1, 8'h55, 1'b1, 1'b0, p, e);
    total++; if (count !== 5'd1) begin bad++; $display("[TB] FAIL empty_wrrd_count got=%0d want=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL empty_wrrd_underflow got=%b want=1", underflow); end
    step(1'b0, 8'h00, 1'b1, 1'b0, p, e);
    total++; if (data_out !== 8'h55 || e !== 8'h55) begin bad++; $display("[TB] FAIL empty_wrrd_data got=%h want=55", data_out); end
    step(1'b0, 8'h00, 1'b0, 1'b1, p, e);
  endtask

  task automatic test_wrap;
    bit p; logic [7:0] e;
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, p, e);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, e);
      total++; if (data_out !== e) begin bad++; $display("[TB] FAIL wrap_pre got=%h want=%h", data_out, e); end
    end
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, p, e);
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("[TB] FAIL wrap_full got=%b/%0d want=1/16", full, count); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, p, e);
      total++; if (data_out !== 8'(8'h20 + i)) begin bad++; $display("[TB] FAIL wrap_data got=%h want=%h", data_out, 8'(8'h20 + i)); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_empty got=%b want=1", empty); end
  endtask

  task automatic test_fwft_reset;
    rst_n_b = 1'b0; @(posedge clk); #1; rst_n_b = 1'b1;
    wr_b = 1'b1; din_b = 8'hA5; @(posedge clk); #1; wr_b = 1'b0;
    total++; if (dout_b !== 8'hA5 || empty_b !== 1'b0) begin bad++; $display("[TB] FAIL fwft_head got=%h/%b want=a5/0", dout_b, empty_b); end
    @(posedge clk); #1;
    total++; if (dout_b !== 8'hA5) begin bad++; $display("[TB] FAIL fwft_hold got=%h want=a5", dout_b); end
    rd_b = 1'b1; @(posedge clk); #1; rd_b = 1'b0;
    total++; if (empty_b !== 1'b1 || dout_b !== 8'h00) begin bad++; $display("[TB] FAIL fwft_pop got=%b/%h want=1/00", empty_b, dout_b); end
    rd_b = 1'b1; @(posedge clk); #1; rd_b = 1'b0;
    total++; if (un_b !== 1'b1) begin bad++; $display("[TB] FAIL fwft_underflow got=%b want=1", un_b); end
    for (int i = 0; i < 7; i++) begin
      wr_b = 1'b1; din_b = 8'(8'h60 + i); @(posedge clk); #1;
    end
    wr_b = 1'b0;
    total++; if (count_b !== 5'd7 || dout_b !== 8'h60) begin bad++; $display("[TB] FAIL fwft_seven got=%0d/%h want=7/60", count_b, dout_b); end
    rst_n_b = 1'b0; @(posedge clk); #1; rst_n_b = 1'b1;
    total++; if (count_b !== 5'd0 || empty_b !== 1'b1 || ae_b !== 1'b1) begin bad++; $display("[TB] FAIL fwft_rst_count got=%0d/%b/%b want=0/1/1", count_b, empty_b, ae_b); end
    total++; if (un_b !== 1'b0 || ov_b !== 1'b0 || dout_b !== 8'h00) begin bad++; $display("[TB] FAIL fwft_rst_flags got=%b/%b/%h want=0/0/00", un_b, ov_b, dout_b); end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = 8'h00;
    rst_n_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0; din_b = 8'h00;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_boundary();
    test_wrap();
    test_fwft_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the fixed 8-bit × 16-entry fifo_mem. It generalises data width and depth and adds programmable almost-full/almost-empty levels, an occupancy count, sticky overflow/underflow flags with clear, and an optional first-word-fall-through (FWFT) read mode. It is a single-clock buffer used between producer and consumer stages in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (≥1)
DEPTH, 16, number of entries; power of 2, ≥4
AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH-1)
AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (1..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CNT_W, $clog2(DEPTH)+1, derived count width; not to be overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
wr  in  1  write request
data_in  in  DATA_W  write data
rd  in  1  read request / pop
err_clr  in  1  clears sticky overflow/underflow
data_out  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AF_LEVEL
almost_empty  out  1  count ≤ AE_LEVEL
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0 at clk edge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Outputs: empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Reset is checked before any other condition. Reset mid-operation discards all contents; count=0 after that edge.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy comes from the count register, not from pointer compare.
- Accepted write: wr & (~full | rd_acc). Stores data_in at wr_ptr; wr_ptr+1.
- Accepted read: rd & ~empty (rd_acc). rd_ptr+1.
- count next = count + wr_acc − rd_acc.
- All flags are combinational decodes of the registered count, so they reflect an edge's operations in the following cycle.
- Full with wr&rd: both accepted, count unchanged, ordering preserved.
- Empty with wr&rd: the write is accepted, the read is rejected, and underflow is set. No bypass of written data.
- Full with wr, ~rd: data dropped; overflow←1.
- Empty with rd: no pointer change; underflow←1; data_out holds.
- Sticky flags: cleared by err_clr. If a set condition and err_clr occur in the same cycle, the set wins.
- FWFT=0: on an accepted read, data_out←mem[rd_ptr] at that edge (1-cycle latency). data_out holds its value otherwise.
- FWFT=1: data_out = mem[rd_ptr] combinationally whenever ~empty, so the head word is visible the cycle after its write edge. rd pops the head. data_out=0 when empty.

Test Plan (DATA_W=8, DEPTH=16, AF=12, AE=4):
1. Reset: hold rst_n=0 for 2 edges with wr=1 → count=0, empty=1, almost_empty=1, full=0, data_out=0x00, overflow=underflow=0; no write taken.
2. Fill/overflow: write 0x01..0x10 → almost_empty drops after the 5th write, almost_full rises after the 12th, full=1 and count=16 after the 16th. Write 0x11 → overflow=1, count=16, 0x11 never read back.
3. Drain/underflow (FWFT=0): 16 single-cycle reads → data_out=0x01..0x10, each valid 1 cycle after rd. Then empty=1. Extra rd → underflow=1, data_out holds 0x10. err_clr → overflow=underflow=0.
4. Simultaneous at boundaries: at full, wr=rd=1 with 0xAA → count stays 16, next read sequence unchanged, 0xAA read last. At empty, wr=rd=1 with 0x55 → count=1, underflow=1, next read returns 0x55.
5. Wrap-around: write/read 10 words, then write 16 words 0x20..0x2F spanning pointer wrap → full=1; read back 0x20..0x2F in order.
6. FWFT=1 + mid-op reset: write 0xA5 → data_out=0xA5 the next cycle with no rd; rd → empty=1, data_out=0x00. Write 7 words then pulse rst_n=0 one edge → count=0, empty=1, flags cleared.
